// File: rtl/netlist_slice_checker_pkg.sv
// Shared constants, FSM state type and golden model for the INV/OAI222 slice checker.
package slice_chk_pkg;

  localparam int unsigned SLICE_W      = 41;
  localparam int unsigned SLICE_NGROUP = 9;
  localparam int unsigned SLICE_CHK_W  = 4 * SLICE_NGROUP;

  // Fibonacci taps for x^41 + x^3 + 1 (state bits 40 and 2)
  localparam logic [SLICE_W-1:0] LFSR_TAPS = 41'h100_0000_0004;

  // Only the group outputs are compared; the bits above them are undriven on the slice
  localparam logic [SLICE_W-1:0] SLICE_MASK =
    {{(SLICE_W - SLICE_CHK_W){1'b0}}, {SLICE_CHK_W{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Expected slice C for the given A/B, with the unchecked upper bits forced to 0
  function automatic logic [SLICE_W-1:0] slice_expect(input logic [SLICE_W-1:0] a,
                                                      input logic [SLICE_W-1:0] b);
    logic [SLICE_W-1:0] e;
    e = '0;
    for (int unsigned g = 0; g < SLICE_NGROUP; g++) begin
      e[4*g]   = ~a[4*g];
      e[4*g+1] = ~b[4*g];
      e[4*g+2] = ~b[4*g+1];
      e[4*g+3] = ~((a[4*g+1] | a[4*g+2]) & (b[4*g+1] | b[4*g+2]) & (a[4*g+3] | b[4*g+3]));
    end
    return e;
  endfunction

endpackage

// File: rtl/netlist_slice_checker_if.sv
// Bus between the checker and the slice under test: stimulus A/B, B drive enable, response C.
interface netlist_slice_checker_if;
  import slice_chk_pkg::*;

  logic [SLICE_W-1:0] vec_a;
  logic [SLICE_W-1:0] vec_b;
  logic               b_oe;
  logic [SLICE_W-1:0] c_in;

  modport master (output vec_a, output vec_b, output b_oe, input c_in);
  modport slave  (input vec_a, input vec_b, input b_oe, output c_in);

endinterface

// File: rtl/netlist_slice_checker_lfsr.sv
// 41-bit Fibonacci LFSR (x^41 + x^3 + 1) with seed load and advance enable.
module slice_chk_lfsr
  import slice_chk_pkg::*;
#(
  parameter logic [SLICE_W-1:0] SEED = 41'h1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               adv_i,
  output logic [SLICE_W-1:0] state_o
);

  logic [SLICE_W-1:0] lfsr_q, lfsr_d;

  // Next state: reseed has priority over advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[SLICE_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // State register, seeded on reset
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/netlist_slice_checker.sv
// Stimulus generator / response checker for the 41-bit INV/OAI222 slice.
// Exhaustive (256 vectors) or LFSR (NUM_VEC vectors) runs; counts mismatching vectors.
// Optional first-failure log enabled by defining SLICE_CHK_ERR_LOG_EN.
module netlist_slice_checker
  import slice_chk_pkg::*;
#(
  parameter int unsigned        SETTLE_CYC = 2,
  parameter int unsigned        NUM_VEC    = 64,
  parameter logic [SLICE_W-1:0] LFSR_SEED  = 41'h1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  netlist_slice_checker_if.master slc,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_cnt,
  output logic [15:0]             first_err_idx,
  output logic [SLICE_W-1:0]      log_a,
  output logic [SLICE_W-1:0]      log_b,
  output logic [SLICE_W-1:0]      log_c,
  output logic [SLICE_W-1:0]      log_mask
);

  localparam int unsigned ROT = 20;

  state_e             state_q;
  logic               mode_q;
  logic [15:0]        k_q;
  logic [3:0]         cnt_q;
  logic [SLICE_W-1:0] vec_a_q, vec_b_q;
  logic               b_oe_q, busy_q, done_q, pass_q;
  logic [15:0]        err_cnt_q, err_cnt_d, first_err_idx_q;

  logic               start_ok;
  logic               lfsr_adv;
  logic [SLICE_W-1:0] lfsr_vec, lfsr_rot;
  logic [SLICE_W-1:0] ex_a, ex_b;
  logic [SLICE_W-1:0] exp_c, diff_c;
  logic               mismatch, last_k;

  // start is honoured only when no run is in progress
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign lfsr_adv = (state_q == ST_DRIVE) && mode_q;

  slice_chk_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (start_ok),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_vec)
  );

  assign lfsr_rot = {lfsr_vec[SLICE_W-ROT-1:0], lfsr_vec[SLICE_W-1:SLICE_W-ROT]};

  // Exhaustive vector: k[3:0] on every A nibble, k[7:4] on every B nibble
  always_comb begin
    ex_a = '0;
    ex_b = '0;
    for (int unsigned g = 0; g < SLICE_NGROUP; g++) begin
      ex_a[4*g +: 4] = k_q[3:0];
      ex_b[4*g +: 4] = k_q[7:4];
    end
  end

  // Response compare against the model of the registered stimulus, plus saturating count
  always_comb begin
    exp_c     = slice_expect(vec_a_q, vec_b_q);
    diff_c    = (slc.c_in & SLICE_MASK) ^ exp_c;
    mismatch  = |diff_c;
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    last_k    = mode_q ? (k_q == 16'(NUM_VEC - 1)) : (k_q == 16'd255);
  end

  // Run sequencer: IDLE -> (DRIVE -> SETTLE -> CHECK)* -> DONE, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mode_q          <= 1'b0;
      k_q             <= '0;
      cnt_q           <= '0;
      vec_a_q         <= '0;
      vec_b_q         <= '0;
      b_oe_q          <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q         <= ST_DRIVE;
            mode_q          <= mode;
            k_q             <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            busy_q          <= 1'b1;
          end
        end
        ST_DRIVE: begin
          vec_a_q <= mode_q ? lfsr_vec : ex_a;
          vec_b_q <= mode_q ? lfsr_rot : ex_b;
          b_oe_q  <= 1'b1;
          cnt_q   <= 4'(SETTLE_CYC - 1);
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == 4'd0) state_q <= ST_CHECK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_CHECK: begin
          err_cnt_q <= err_cnt_d;
          // err_cnt never returns to 0 within a run, so zero marks "no failure yet"
          if (mismatch && (err_cnt_q == 16'd0)) first_err_idx_q <= k_q;
          if (last_k) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            b_oe_q  <= 1'b0;
            pass_q  <= (err_cnt_d == 16'd0);
          end else begin
            k_q     <= k_q + 16'd1;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign slc.vec_a     = vec_a_q;
  assign slc.vec_b     = vec_b_q;
  assign slc.b_oe      = b_oe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;

`ifdef SLICE_CHK_ERR_LOG_EN
  logic [SLICE_W-1:0] log_a_q, log_b_q, log_c_q, log_mask_q;

  // First-failure capture; cleared by each accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      log_a_q    <= '0;
      log_b_q    <= '0;
      log_c_q    <= '0;
      log_mask_q <= '0;
    end else if (start_ok) begin
      log_a_q    <= '0;
      log_b_q    <= '0;
      log_c_q    <= '0;
      log_mask_q <= '0;
    end else if ((state_q == ST_CHECK) && mismatch && (err_cnt_q == 16'd0)) begin
      log_a_q    <= vec_a_q;
      log_b_q    <= vec_b_q;
      log_c_q    <= slc.c_in;
      log_mask_q <= diff_c;
    end
  end

  assign log_a    = log_a_q;
  assign log_b    = log_b_q;
  assign log_c    = log_c_q;
  assign log_mask = log_mask_q;
`else
  assign log_a    = '0;
  assign log_b    = '0;
  assign log_c    = '0;
  assign log_mask = '0;
`endif

endmodule
